// File: rtl/osc_pattern_gen.sv
// Two-level float32 pattern generator: base level for N cycles, peak level for M
// cycles, repeated K bursts (or continuously), with all settings captured at start.
module osc_pattern_gen #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [DATA_W-1:0] i_idle_data,
    input  logic [DATA_W-1:0] i_base_data,
    input  logic [DATA_W-1:0] i_peak_data,
    input  logic [CNT_W-1:0]  i_base_len,
    input  logic [CNT_W-1:0]  i_peak_len,
    input  logic [CNT_W-1:0]  i_burst_cnt,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_burst_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BASE = 2'd1;
    localparam logic [1:0] ST_PEAK = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_reg,      state_next;
    logic [DATA_W-1:0] base_data_reg,  base_data_next;
    logic [DATA_W-1:0] peak_data_reg,  peak_data_next;
    logic [CNT_W-1:0]  base_last_reg,  base_last_next;
    logic [CNT_W-1:0]  peak_last_reg,  peak_last_next;
    logic [CNT_W-1:0]  burst_cnt_reg,  burst_cnt_next;
    logic [CNT_W-1:0]  phase_cnt_reg,  phase_cnt_next;
    logic [CNT_W-1:0]  burst_done_reg, burst_done_next;
    logic [DATA_W-1:0] data_reg,       data_next;
    logic              busy_reg,       busy_next;
    logic              done_reg,       done_next;
    logic [CNT_W-1:0]  burst_inc;

    assign burst_inc = burst_done_reg + CNT_W'(1);

    always_comb begin
        state_next      = state_reg;
        base_data_next  = base_data_reg;
        peak_data_next  = peak_data_reg;
        base_last_next  = base_last_reg;
        peak_last_next  = peak_last_reg;
        burst_cnt_next  = burst_cnt_reg;
        phase_cnt_next  = phase_cnt_reg;
        burst_done_next = burst_done_reg;
        data_next       = data_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                data_next = i_idle_data;
                busy_next = 1'b0;
                if (i_start && !i_stop) begin
                    // Lengths are stored as "last phase index" so zero and one both mean one cycle.
                    base_data_next  = i_base_data;
                    peak_data_next  = i_peak_data;
                    base_last_next  = (i_base_len == '0) ? '0 : i_base_len - CNT_W'(1);
                    peak_last_next  = (i_peak_len == '0) ? '0 : i_peak_len - CNT_W'(1);
                    burst_cnt_next  = i_burst_cnt;
                    burst_done_next = '0;
                    phase_cnt_next  = '0;
                    state_next      = ST_BASE;
                    data_next       = i_base_data;
                    busy_next       = 1'b1;
                end
            end

            ST_BASE: begin
                if (i_stop) begin
                    state_next = ST_IDLE;
                    data_next  = i_idle_data;
                    busy_next  = 1'b0;
                end else if (phase_cnt_reg == base_last_reg) begin
                    state_next     = ST_PEAK;
                    phase_cnt_next = '0;
                    data_next      = peak_data_reg;
                end else begin
                    phase_cnt_next = phase_cnt_reg + CNT_W'(1);
                end
            end

            ST_PEAK: begin
                if (i_stop) begin
                    state_next = ST_IDLE;
                    data_next  = i_idle_data;
                    busy_next  = 1'b0;
                end else if (phase_cnt_reg == peak_last_reg) begin
                    burst_done_next = burst_inc;
                    phase_cnt_next  = '0;
                    // A zero burst count never matches, so continuous runs simply wrap the counter.
                    if ((burst_cnt_reg != '0) && (burst_inc == burst_cnt_reg)) begin
                        state_next = ST_DONE;
                        data_next  = i_idle_data;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_BASE;
                        data_next  = base_data_reg;
                    end
                end else begin
                    phase_cnt_next = phase_cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                data_next  = i_idle_data;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            base_data_reg  <= '0;
            peak_data_reg  <= '0;
            base_last_reg  <= '0;
            peak_last_reg  <= '0;
            burst_cnt_reg  <= '0;
            phase_cnt_reg  <= '0;
            burst_done_reg <= '0;
            data_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            base_data_reg  <= base_data_next;
            peak_data_reg  <= peak_data_next;
            base_last_reg  <= base_last_next;
            peak_last_reg  <= peak_last_next;
            burst_cnt_reg  <= burst_cnt_next;
            phase_cnt_reg  <= phase_cnt_next;
            burst_done_reg <= burst_done_next;
            data_reg       <= data_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign o_data       = data_reg;
    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_burst_done = burst_done_reg;

endmodule
